// File: rtl/ksa_seq_ctrl.sv
// Multi-precision add/subtract sequencer: streams wide operands one word per cycle,
// least significant word first, through a single 8-bit Kogge-Stone slice.

module ksa_top_compact (
   input  logic       c0,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] s,
   output logic       c32
);

   logic [7:0] p0, g0, p1, g1, p2, g2, g3;

   // Carry-in is absorbed into bit 0's generate so the prefix tree yields G[i:0] incl. c0
   assign p0 = a ^ b;
   assign g0 = (a & b) | {7'b0, p0[0] & c0};

   assign g1 = g0 | (p0 & {g0[6:0], 1'b0});
   assign p1 = p0 & {p0[6:0], 1'b1};
   assign g2 = g1 | (p1 & {g1[5:0], 2'b0});
   assign p2 = p1 & {p1[5:0], 2'b11};
   assign g3 = g2 | (p2 & {g2[3:0], 4'b0});

   assign s   = p0 ^ {g3[6:0], c0};
   assign c32 = g3[7];

endmodule

module ksa_seq_ctrl #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned WORDS = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH*WORDS-1:0] in_a,
   input  logic [WIDTH*WORDS-1:0] in_b,
   input  logic                   in_cin,
   input  logic                   in_sub,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH*WORDS-1:0] out_sum,
   output logic                   out_cout,
   output logic                   busy
);

   localparam int unsigned TW = WIDTH * WORDS;
   localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   logic [TW-1:0]   a_reg;
   logic [TW-1:0]   b_reg;
   logic            carry;
   logic [IW-1:0]   idx;
   logic [WIDTH-1:0] a_word;
   logic [WIDTH-1:0] b_word;
   logic [WIDTH-1:0] slice_s;
   logic            slice_c;

   assign in_ready = (state == IDLE);

   // Select the current word of each operand
   always_comb begin
      a_word = '0;
      b_word = '0;
      for (int unsigned i = 0; i < WORDS; i++) begin
         if (idx == IW'(i)) begin
            a_word = a_reg[i*WIDTH +: WIDTH];
            b_word = b_reg[i*WIDTH +: WIDTH];
         end
      end
   end

   ksa_top_compact u_slice (
      .c0  (carry),
      .a   (a_word),
      .b   (b_word),
      .s   (slice_s),
      .c32 (slice_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         carry     <= 1'b0;
         idx       <= '0;
         out_sum   <= '0;
         out_cout  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  // Subtract is A + ~B + 1
                  a_reg <= in_a;
                  b_reg <= in_sub ? ~in_b : in_b;
                  carry <= in_sub ? 1'b1 : in_cin;
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               for (int unsigned i = 0; i < WORDS; i++) begin
                  if (idx == IW'(i)) out_sum[i*WIDTH +: WIDTH] <= slice_s;
               end
               carry <= slice_c;
               idx   <= idx + IW'(1);
               if (idx == LAST) begin
                  idx       <= '0;
                  out_cout  <= slice_c;
                  out_valid <= 1'b1;
                  busy      <= 1'b0;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ksa_seq_ctrl.sv
// Self-checking bench for ksa_seq_ctrl: directed scenarios on a 4-word build plus
// randomized add/sub against an arithmetic reference on 1-, 4- and 8-word builds.

module tb_ksa_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] in_a, in_b;
   logic        in_cin, in_sub, out_ready;
   logic        iv1, iv4, iv8;
   logic        r1, r4, r8;
   logic        ov1, ov4, ov8;
   logic        c1, c4, c8;
   logic        b1, b4, b8;
   logic [7:0]  s1;
   logic [31:0] s4;
   logic [63:0] s8;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ksa_seq_ctrl #(.WIDTH(8), .WORDS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(r4), .in_a(in_a[31:0]),
      .in_b(in_b[31:0]), .in_cin(in_cin), .in_sub(in_sub), .out_valid(ov4),
      .out_ready(out_ready), .out_sum(s4), .out_cout(c4), .busy(b4));

   ksa_seq_ctrl #(.WIDTH(8), .WORDS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(r1), .in_a(in_a[7:0]),
      .in_b(in_b[7:0]), .in_cin(in_cin), .in_sub(in_sub), .out_valid(ov1),
      .out_ready(out_ready), .out_sum(s1), .out_cout(c1), .busy(b1));

   ksa_seq_ctrl #(.WIDTH(8), .WORDS(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(r8), .in_a(in_a),
      .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .out_valid(ov8),
      .out_ready(out_ready), .out_sum(s8), .out_cout(c8), .busy(b8));

   // Reference: {cout, sum} = A + B + cin, or A + ~B + 1, modulo 2^(8*w)
   function automatic logic [64:0] ref_model(input int w, input logic [63:0] a,
                                             input logic [63:0] b, input logic cin,
                                             input logic sub);
      int          bits;
      logic [63:0] mask, ae, be;
      logic [64:0] full;
      bits = 8 * w;
      mask = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
      ae   = a & mask;
      be   = (sub ? ~b : b) & mask;
      full = {1'b0, ae} + {1'b0, be} + 65'(sub ? 1'b1 : cin);
      return {full[bits], full[63:0] & mask};
   endfunction

   function automatic logic rdy(input int w);
      return (w == 1) ? r1 : (w == 4) ? r4 : r8;
   endfunction
   function automatic logic ovld(input int w);
      return (w == 1) ? ov1 : (w == 4) ? ov4 : ov8;
   endfunction
   function automatic logic bsy(input int w);
      return (w == 1) ? b1 : (w == 4) ? b4 : b8;
   endfunction
   function automatic logic coutv(input int w);
      return (w == 1) ? c1 : (w == 4) ? c4 : c8;
   endfunction
   function automatic logic [63:0] sumv(input int w);
      return (w == 1) ? {56'b0, s1} : (w == 4) ? {32'b0, s4} : s8;
   endfunction

   task automatic set_valid(input int w, input logic v);
      case (w)
         1:       iv1 = v;
         4:       iv4 = v;
         default: iv8 = v;
      endcase
   endtask

   // Issue one operation and wait for its result; caller owns out_ready
   task automatic run_op(input int w, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic sub, output logic [63:0] sum,
                         output logic cout, output int lat, output int bcnt, output bit ok);
      int t;
      in_a = a; in_b = b; in_cin = cin; in_sub = sub;
      set_valid(w, 1'b1);
      ok = 1'b1; lat = 0; bcnt = 0; t = 0;
      while (!rdy(w) && t < 50) begin @(posedge clk); #1; t++; end
      if (!rdy(w)) ok = 1'b0;
      @(posedge clk); #1;
      set_valid(w, 1'b0);
      while (!ovld(w) && lat < 100) begin
         if (bsy(w)) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
      if (!ovld(w)) ok = 1'b0;
      sum  = sumv(w);
      cout = coutv(w);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; iv1 = 1'b0; iv8 = 1'b0; iv4 = 1'b1; out_ready = 1'b1;
      in_cin = 1'b1; in_sub = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
         @(posedge clk); #1;
         n_checks++;
         if ({ov4, s4, c4, b4} !== 35'b0 || r4 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold[%0d]: ov=%b sum=%h cout=%b busy=%b ready=%b, need 0/0/0/0/1",
                     k, ov4, s4, c4, b4, r4);
         end
      end
      iv4 = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (r4 !== 1'b1 || b4 !== 1'b0 || ov4 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: ready=%b busy=%b ov=%b, need 1/0/0", r4, b4, ov4);
      end
   endtask

   task automatic test_add();
      logic [63:0] s; logic c; int lat, bc; bit ok;
      out_ready = 1'b1;
      run_op(4, 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, s, c, lat, bc, ok);
      n_checks++;
      if (!ok || s !== 64'h0 || c !== 1'b1) begin
         n_fail++;
         $display("FAIL add_wrap: ok=%b sum=%h cout=%b, need 00000000/1", ok, s, c);
      end
      n_checks++;
      if (lat !== 4 || bc !== 4) begin
         n_fail++;
         $display("FAIL add_latency: lat=%0d busy_cycles=%0d, need 4/4", lat, bc);
      end
      @(posedge clk); #1;
      n_checks++;
      if (ov4 !== 1'b0 || r4 !== 1'b1) begin
         n_fail++;
         $display("FAIL add_consume: ov=%b ready=%b, need 0/1", ov4, r4);
      end
      run_op(4, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1, 1'b0, s, c, lat, bc, ok);
      n_checks++;
      if (!ok || s !== 64'hFFFF_FFFF || c !== 1'b1) begin
         n_fail++;
         $display("FAIL add_cin: ok=%b sum=%h cout=%b, need ffffffff/1", ok, s, c);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_sub();
      logic [63:0] s; logic c; int lat, bc; bit ok;
      out_ready = 1'b1;
      for (int ci = 0; ci < 2; ci++) begin
         run_op(4, 64'd7, 64'd5, 1'(ci), 1'b1, s, c, lat, bc, ok);
         n_checks++;
         if (!ok || s !== 64'h2 || c !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_7_5 cin=%0d: sum=%h cout=%b, need 00000002/1", ci, s, c);
         end
         @(posedge clk); #1;
         run_op(4, 64'd5, 64'd7, 1'(ci), 1'b1, s, c, lat, bc, ok);
         n_checks++;
         if (!ok || s !== 64'hFFFF_FFFE || c !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_5_7 cin=%0d: sum=%h cout=%b, need fffffffe/0", ci, s, c);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] s; logic c; int lat, bc; bit ok;
      out_ready = 1'b0;
      run_op(4, 64'h1234_5678, 64'h9ABC_DEF0, 1'b0, 1'b0, s, c, lat, bc, ok);
      n_checks++;
      if (!ok || s !== 64'hACF1_3568 || c !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_result: sum=%h cout=%b, need acf13568/0", s, c);
      end
      for (int k = 0; k < 10; k++) begin
         iv4 = 1'(k % 2);
         in_a = {$urandom, $urandom};
         @(posedge clk); #1;
         n_checks++;
         if (ov4 !== 1'b1 || s4 !== 32'hACF1_3568 || c4 !== 1'b0 || r4 !== 1'b0 || b4 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: ov=%b sum=%h cout=%b ready=%b busy=%b, need 1/acf13568/0/0/0",
                     k, ov4, s4, c4, r4, b4);
         end
      end
      // in_valid and out_ready together in DONE: only the result handshake happens
      iv4 = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      iv4 = 1'b0;
      n_checks++;
      if (ov4 !== 1'b0 || r4 !== 1'b1 || b4 !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release: ov=%b ready=%b busy=%b, need 0/1/0", ov4, r4, b4);
      end
      repeat (3) begin
         @(posedge clk); #1;
         n_checks++;
         if (ov4 !== 1'b0 || b4 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_once: ov=%b busy=%b, need 0/0", ov4, b4);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      logic [63:0] s; logic c; int lat, bc; bit ok, seen;
      out_ready = 1'b1;
      in_a = 64'h00FF_00FF; in_b = 64'h0001_0001; in_cin = 1'b0; in_sub = 1'b0;
      iv4 = 1'b1;
      @(posedge clk); #1;
      iv4 = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      n_checks++;
      if (b4 !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_pre: busy=%b, need 1", b4);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (ov4 !== 1'b0 || b4 !== 1'b0 || s4 !== 32'h0 || r4 !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_async: ov=%b busy=%b sum=%h ready=%b, need 0/0/0/1", ov4, b4, s4, r4);
      end
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin @(posedge clk); #1; if (ov4 !== 1'b0) seen = 1'b1; end
      n_checks++;
      if (seen) begin
         n_fail++;
         $display("FAIL abort_no_valid: out_valid seen=1, need 0");
      end
      run_op(4, 64'h0, 64'h0, 1'b0, 1'b0, s, c, lat, bc, ok);
      n_checks++;
      if (!ok || s !== 64'h0 || c !== 1'b0 || lat !== 4) begin
         n_fail++;
         $display("FAIL abort_clean: sum=%h cout=%b lat=%0d, need 00000000/0/4", s, c, lat);
      end
      @(posedge clk); #1;
      // Reset while holding a result in DONE
      out_ready = 1'b0;
      run_op(4, 64'hFFFF_FFFF, 64'h1, 1'b1, 1'b0, s, c, lat, bc, ok);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (ov4 !== 1'b0 || c4 !== 1'b0 || s4 !== 32'h0) begin
         n_fail++;
         $display("FAIL abort_done: ov=%b cout=%b sum=%h, need 0/0/0", ov4, c4, s4);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic rand_ops(output logic [63:0] a, output logic [63:0] b,
                           output logic ci, output logic sb);
      int mode;
      mode = $urandom_range(0, 4);
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      ci = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      if (mode == 1) a = 64'hFFFF_FFFF_FFFF_FFFF;
      if (mode == 2) b = a;
      if (mode == 3) b = 64'h0;
   endtask

   task automatic test_back_to_back(input int w, input int n);
      logic [63:0] a, b; logic ci, sb; logic [64:0] exp;
      int t, lat, acc, prev_acc;
      out_ready = 1'b1;
      prev_acc = -1;
      rand_ops(a, b, ci, sb);
      in_a = a; in_b = b; in_cin = ci; in_sub = sb;
      set_valid(w, 1'b1);
      for (int k = 0; k < n; k++) begin
         t = 0;
         while (!rdy(w) && t < 50) begin @(posedge clk); #1; t++; end
         if (!rdy(w)) begin
            n_checks++; n_fail++;
            $display("FAIL b2b_w%0d_ready[%0d]: in_ready=0 after 50 cycles, need 1", w, k);
            break;
         end
         exp = ref_model(w, a, b, ci, sb);
         @(posedge clk); #1;
         acc = cyc;
         if (prev_acc >= 0) begin
            n_checks++;
            if (acc - prev_acc != w + 2) begin
               n_fail++;
               $display("FAIL b2b_w%0d_rate[%0d]: interval=%0d, need %0d", w, k, acc - prev_acc, w + 2);
            end
         end
         prev_acc = acc;
         rand_ops(a, b, ci, sb);
         in_a = a; in_b = b; in_cin = ci; in_sub = sb;
         lat = 0;
         while (!ovld(w) && lat < 100) begin @(posedge clk); #1; lat++; end
         n_checks++;
         if (lat != w) begin
            n_fail++;
            $display("FAIL b2b_w%0d_latency[%0d]: lat=%0d, need %0d", w, k, lat, w);
         end
         n_checks++;
         if (sumv(w) !== exp[63:0] || coutv(w) !== exp[64]) begin
            n_fail++;
            $display("FAIL b2b_w%0d_result[%0d]: sum=%h cout=%b, need %h/%b",
                     w, k, sumv(w), coutv(w), exp[63:0], exp[64]);
         end
      end
      set_valid(w, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back(4, 1000);
      test_back_to_back(1, 200);
      test_back_to_back(8, 200);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
